// File: rtl/n_b10_pkg.sv
// Shared constants, digit type and load clamp for the n4_b10 BCD counter family.
package n_b10_pkg;

  localparam int B10_DIGIT_W  = 4;
  localparam int B10_N_DIGITS = 4;
  localparam logic [B10_DIGIT_W-1:0] B10_MAX_DIGIT = 4'd9;

  typedef logic [B10_DIGIT_W-1:0] b10_digit_t;

  // Preset nibbles above 9 would leave a non-BCD digit behind, so pin them to 9.
  function automatic b10_digit_t b10_clamp(input logic [B10_DIGIT_W-1:0] i_nibble);
    b10_digit_t w_res;
    if (i_nibble > B10_MAX_DIGIT) begin
      w_res = B10_MAX_DIGIT;
    end else begin
      w_res = i_nibble;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/b10_down_digit.sv
// One BCD down-counting digit: sync reset > load (clamped) > borrow-in decrement.
module b10_down_digit
  import n_b10_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_ei,
  output logic [3:0] o_digit,
  output logic       o_eu
);

  b10_digit_t r_digit;

  // Digit register; a borrow into a zero digit wraps it to 9.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= b10_clamp(i_load_val);
    end else if (i_ei) begin
      if (r_digit == 4'd0) begin
        r_digit <= B10_MAX_DIGIT;
      end else begin
        r_digit <= r_digit - 4'd1;
      end
    end else begin
      r_digit <= r_digit;
    end
  end

  assign o_digit = r_digit;
  assign o_eu    = i_ei & (r_digit == 4'd0);

endmodule

// File: rtl/n4_b10_down_counter.sv
// Four-digit BCD down counter with load and cascadable borrow-out.
// Define DOWN_COUNTER_SAT_EN to hold at 0000 instead of wrapping to 9999.
module n4_b10_down_counter
  import n_b10_pkg::*;
(
  input  logic        m_clock,
  input  logic        m_reset,
  input  logic        m_ei,
  input  logic        m_load,
  input  logic [15:0] d_in,
  output logic        eu,
  output logic        zero,
  output logic [3:0]  q03_q00,
  output logic [3:0]  q13_q10,
  output logic [3:0]  q23_q20,
  output logic [3:0]  q33_q30
);

  logic [B10_N_DIGITS:0]   w_ei;
  logic [B10_N_DIGITS-1:0] w_eu;
  b10_digit_t              w_digit [B10_N_DIGITS];
  logic                    w_zero;

  assign w_zero = (w_digit[0] == 4'd0) & (w_digit[1] == 4'd0) &
                  (w_digit[2] == 4'd0) & (w_digit[3] == 4'd0);

`ifdef DOWN_COUNTER_SAT_EN
  // Saturating: no borrow enters the chain once everything is already zero.
  assign w_ei[0] = m_ei & ~w_zero;
  assign eu      = m_ei & ~m_load & w_zero;
`else
  assign w_ei[0] = m_ei;
  // Borrow out of the top digit is exactly m_ei & zero in wrap mode.
  assign eu      = w_ei[B10_N_DIGITS] & ~m_load;
`endif

  for (genvar g = 0; g < B10_N_DIGITS; g++) begin : g_digit
    b10_down_digit u_digit (
      .i_clk      (m_clock),
      .i_rst      (m_reset),
      .i_load     (m_load),
      .i_load_val (d_in[g*B10_DIGIT_W +: B10_DIGIT_W]),
      .i_ei       (w_ei[g]),
      .o_digit    (w_digit[g]),
      .o_eu       (w_eu[g])
    );
    assign w_ei[g+1] = w_eu[g];
  end

  assign zero    = w_zero;
  assign q03_q00 = w_digit[0];
  assign q13_q10 = w_digit[1];
  assign q23_q20 = w_digit[2];
  assign q33_q30 = w_digit[3];

endmodule

// File: tb/tb_n4_b10_down_counter.sv
// Directed bench for n4_b10_down_counter (wrap mode, or saturating with DOWN_COUNTER_SAT_EN).
module tb_n4_b10_down_counter;

  logic        m_clock = 1'b0;
  logic        m_reset = 1'b1;
  logic        m_ei    = 1'b1;
  logic        m_load  = 1'b0;
  logic [15:0] d_in    = 16'h0000;
  logic        eu, zero;
  logic [3:0]  q03_q00, q13_q10, q23_q20, q33_q30;

  int n_checks = 0;
  int n_errors = 0;

  n4_b10_down_counter dut (
    .m_clock (m_clock),
    .m_reset (m_reset),
    .m_ei    (m_ei),
    .m_load  (m_load),
    .d_in    (d_in),
    .eu      (eu),
    .zero    (zero),
    .q03_q00 (q03_q00),
    .q13_q10 (q13_q10),
    .q23_q20 (q23_q20),
    .q33_q30 (q33_q30)
  );

  always #5 m_clock = ~m_clock;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  function automatic logic [15:0] value();
    return {q33_q30, q23_q20, q13_q10, q03_q00};
  endfunction

  logic [15:0] exp_seq [5];
  logic [15:0] exp_after_zero;

  initial begin
`ifdef DOWN_COUNTER_SAT_EN
    exp_seq = '{16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    exp_after_zero = 16'h0000;
`else
    exp_seq = '{16'h0002, 16'h0001, 16'h0000, 16'h9999, 16'h9998};
    exp_after_zero = 16'h9999;
`endif

    // Reset for two edges with enable high
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_val", value(), 16'h0000);
      check_val("rst_zero", {15'd0, zero}, 16'h0001);
      check_val("rst_eu", {15'd0, eu}, 16'h0001);
    end
    m_reset = 1'b0;
    #1;
    check_val("rel_eu", {15'd0, eu}, 16'h0001);
    tick();
    check_val("rel_wrap", value(), exp_after_zero);

    // Load 1000 then borrow across three digits
    m_load = 1'b1; m_ei = 1'b0; d_in = 16'h1000;
    tick();
    check_val("ld1000", value(), 16'h1000);
    m_load = 1'b0; m_ei = 1'b1;
    #1;
    check_val("ld1000_eu", {15'd0, eu}, 16'h0000);
    check_val("ld1000_zero", {15'd0, zero}, 16'h0000);
    tick();
    check_val("dec0999", value(), 16'h0999);
    check_val("dec0999_eu", {15'd0, eu}, 16'h0000);
    check_val("dec0999_zero", {15'd0, zero}, 16'h0000);

    // Hold with nothing active
    m_ei = 1'b0;
    tick();
    check_val("hold", value(), 16'h0999);

    // Load 0003 and count through zero
    m_load = 1'b1; d_in = 16'h0003;
    tick();
    check_val("ld0003", value(), 16'h0003);
    m_load = 1'b0; m_ei = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("cnt_val", value(), exp_seq[i]);
      check_val("cnt_eu", {15'd0, eu}, {15'd0, exp_seq[i] == 16'h0000});
    end

    // Clamp of non-BCD nibbles
    m_load = 1'b1; m_ei = 1'b0; d_in = 16'hFA5C;
    tick();
    check_val("clamp", value(), 16'h9959);

    // Load and enable together at 0000
    d_in = 16'h0000;
    tick();
    check_val("ld0000", value(), 16'h0000);
    m_ei = 1'b1;
    #1;
    check_val("ldei_eu", {15'd0, eu}, 16'h0000);
    tick();
    check_val("ldei_val", value(), 16'h0000);
    m_load = 1'b0;
    #1;
    check_val("ldei_eu_after", {15'd0, eu}, 16'h0001);

    // Reset mid-count
    m_load = 1'b1; m_ei = 1'b0; d_in = 16'h0420;
    tick();
    check_val("ld0420", value(), 16'h0420);
    m_load = 1'b0; m_ei = 1'b1; m_reset = 1'b1;
    tick();
    check_val("midrst", value(), 16'h0000);
    m_reset = 1'b0;
    tick();
    check_val("midrst_resume", value(), exp_after_zero);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
